// File: rtl/acc_issue_rf.sv
// acc_issue_rf: CPU-side issue stage for the accelerator port.
//
// Holds the FP register file, a per-register pending scoreboard and a
// one-entry issue register. Decoded instructions are accepted when no
// RAW/WAW hazard exists (after this cycle's write-back clears its bit), their
// operands are read with write-back bypass, and the registered result is
// presented to the controller on the acc_* port.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-high reset
//   in_*                   front-end instruction (valid/ready handshake)
//   acc_*                  issued instruction to the controller (valid/ready)
//   wb_*                   controller write-back stream
//   pending_o              scoreboard bits
//   idle_o                 nothing pending and issue register empty
//   err_o                  write-back to a non-pending register (sticky)
//
// Optional feature: define ACC_ISSUE_SB_CHECK_EN to build the scoreboard
// check behind err_o; otherwise err_o is tied low.
module acc_issue_rf #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
  parameter int unsigned PAYLOAD_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ADDR_W-1:0]     in_rd_i,
  input  logic                  in_rd_used_i,
  input  logic [3*ADDR_W-1:0]   in_rs_i,
  input  logic [2:0]            in_rs_used_i,
  input  logic [PAYLOAD_W-1:0]  in_payload_i,
  output logic                  acc_valid_o,
  input  logic                  acc_ready_i,
  output logic [ADDR_W-1:0]     acc_rd_o,
  output logic [3*DATA_W-1:0]   acc_op_o,
  output logic [PAYLOAD_W-1:0]  acc_payload_o,
  input  logic                  wb_wren_i,
  input  logic [ADDR_W-1:0]     wb_waddr_i,
  input  logic [DATA_W-1:0]     wb_wdata_i,
  output logic [NUM_REGS-1:0]   pending_o,
  output logic                  idle_o,
  output logic                  err_o
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]    pending_q, pending_d;
  logic [NUM_REGS-1:0]    wb_mask, pend_eff;
  logic [ADDR_W-1:0]      rd_q;
  logic [3*DATA_W-1:0]    op_q, op_d;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic [ADDR_W-1:0]      rs_idx [3];
  logic                   hazard;
  logic                   accept;

  // Scoreboard as seen after this cycle's write-back retires its register.
  always_comb begin
    wb_mask = '0;
    if (wb_wren_i) wb_mask[wb_waddr_i] = 1'b1;
    pend_eff = pending_q & ~wb_mask;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) rs_idx[k] = in_rs_i[k*ADDR_W +: ADDR_W];
  end

  always_comb begin
    hazard = in_rd_used_i & pend_eff[in_rd_i];
    for (int k = 0; k < 3; k++) begin
      if (in_rs_used_i[k] && pend_eff[rs_idx[k]]) hazard = 1'b1;
    end
  end

  assign in_ready_o = ((state_q == StEmpty) | acc_ready_i) & ~hazard;
  assign accept     = in_valid_i & in_ready_o;

  // Operand read with bypass from the write-back landing this cycle.
  always_comb begin
    op_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (in_rs_used_i[k]) begin
        if (wb_wren_i && (wb_waddr_i == rs_idx[k])) begin
          op_d[k*DATA_W +: DATA_W] = wb_wdata_i;
        end else begin
          op_d[k*DATA_W +: DATA_W] = regs_q[rs_idx[k]];
        end
      end
    end
  end

  // WAW blocking guarantees rd is clear in pend_eff, so set-after-clear
  // gives set priority when rd has just retired.
  always_comb begin
    pending_d = pend_eff;
    if (accept && in_rd_used_i) pending_d[in_rd_i] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (acc_ready_i && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      state_q   <= StEmpty;
      pending_q <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      payload_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (accept) begin
        rd_q      <= in_rd_i;
        op_q      <= op_d;
        payload_q <= in_payload_i;
      end
      if (wb_wren_i) regs_q[wb_waddr_i] <= wb_wdata_i;
    end
  end

`ifdef ACC_ISSUE_SB_CHECK_EN
  logic err_q;

  // Checked against the scoreboard before this cycle's clear.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      err_q <= 1'b0;
    end else if (wb_wren_i && !pending_q[wb_waddr_i]) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign acc_valid_o   = (state_q == StFull);
  assign acc_rd_o      = rd_q;
  assign acc_op_o      = op_q;
  assign acc_payload_o = payload_q;
  assign pending_o     = pending_q;
  assign idle_o        = ~(|pending_q) & (state_q == StEmpty);

endmodule

// File: tb/tb_acc_issue_rf.sv
module tb_acc_issue_rf;

  localparam int NR = 32;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int PW = 16;

`ifdef ACC_ISSUE_SB_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_rd_used;
  logic [AW-1:0] in_rd;
  logic [3*AW-1:0] in_rs;
  logic [2:0]    in_rs_used;
  logic [PW-1:0] in_payload;
  logic          acc_valid, acc_ready;
  logic [AW-1:0] acc_rd;
  logic [3*DW-1:0] acc_op;
  logic [PW-1:0] acc_payload;
  logic          wb_wren;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic [NR-1:0] pending;
  logic          idle, err;

  always #5 clk = ~clk;

  acc_issue_rf dut (
    .clk_i        (clk),
    .rst_ni       (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_rd_i      (in_rd),
    .in_rd_used_i (in_rd_used),
    .in_rs_i      (in_rs),
    .in_rs_used_i (in_rs_used),
    .in_payload_i (in_payload),
    .acc_valid_o  (acc_valid),
    .acc_ready_i  (acc_ready),
    .acc_rd_o     (acc_rd),
    .acc_op_o     (acc_op),
    .acc_payload_o(acc_payload),
    .wb_wren_i    (wb_wren),
    .wb_waddr_i   (wb_waddr),
    .wb_wdata_i   (wb_wdata),
    .pending_o    (pending),
    .idle_o       (idle),
    .err_o        (err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only.
  logic [DW-1:0]   m_reg [NR];
  logic [NR-1:0]   m_pend;
  bit              m_full;
  logic [AW-1:0]   m_rd;
  logic [3*DW-1:0] m_op;
  logic [PW-1:0]   m_pl;
  bit              m_err;
  bit              cmp_en = 1'b0;

  function automatic bit exp_ready();
    logic [NR-1:0] pe = m_pend;
    bit hz;
    if (wb_wren) pe[wb_waddr] = 1'b0;
    hz = in_rd_used && pe[in_rd];
    for (int k = 0; k < 3; k++) if (in_rs_used[k] && pe[in_rs[k*AW +: AW]]) hz = 1'b1;
    return (!m_full || acc_ready) && !hz;
  endfunction

  function automatic logic [3*DW-1:0] model_ops();
    logic [3*DW-1:0] o = '0;
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] r = in_rs[k*AW +: AW];
      if (in_rs_used[k]) o[k*DW +: DW] = (wb_wren && wb_waddr == r) ? wb_wdata : m_reg[r];
    end
    return o;
  endfunction

  function automatic logic [NR-1:0] next_pend();
    logic [NR-1:0] pe = m_pend;
    if (wb_wren) pe[wb_waddr] = 1'b0;
    if (in_valid && exp_ready() && in_rd_used) pe[in_rd] = 1'b1;
    return pe;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= '0;
      m_full <= 1'b0;
      m_rd   <= '0;
      m_op   <= '0;
      m_pl   <= '0;
      m_err  <= 1'b0;
      for (int i = 0; i < NR; i++) m_reg[i] <= '0;
    end else begin
      if (in_valid && exp_ready()) begin
        m_full <= 1'b1;
        m_rd   <= in_rd;
        m_op   <= model_ops();
        m_pl   <= in_payload;
      end else if (acc_ready) begin
        m_full <= 1'b0;
      end
      m_pend <= next_pend();
      if (wb_wren) begin
        m_reg[wb_waddr] <= wb_wdata;
        if (ErrEn && !m_pend[wb_waddr]) m_err <= 1'b1;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("acc_valid", acc_valid, m_full);
      if (m_full) begin
        chk("acc_rd", acc_rd, m_rd);
        chk("acc_op0", acc_op[63:0], m_op[63:0]);
        chk("acc_op1", acc_op[127:64], m_op[127:64]);
        chk("acc_op2", acc_op[191:128], m_op[191:128]);
        chk("acc_payload", acc_payload, m_pl);
      end
      chk("pending", pending, m_pend);
      chk("idle", idle, (m_pend == '0) && !m_full);
      chk("in_ready", in_ready, exp_ready());
      chk("err", err, m_err);
    end
  end

  task automatic drive(input bit v, input logic [AW-1:0] rd, input bit rdu,
                       input logic [3*AW-1:0] rs, input logic [2:0] rsu,
                       input logic [PW-1:0] pl);
    in_valid   = v;
    in_rd      = rd;
    in_rd_used = rdu;
    in_rs      = rs;
    in_rs_used = rsu;
    in_payload = pl;
  endtask

  task automatic wbset(input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_wren  = en;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    acc_ready = 1'b1;
    drive(0, 0, 0, '0, 3'b000, '0);
    wbset(0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_acc_valid", acc_valid, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Load reg1/reg2 through the scoreboard.
    drive(1, 1, 1, '0, 3'b000, '0); step();
    drive(1, 2, 1, '0, 3'b000, '0); step();
    drive(0, 0, 0, '0, 3'b000, '0);
    wbset(1, 1, 64'h3FF0000000000000); step();
    wbset(1, 2, 64'h4000000000000000); step();
    wbset(0, 0, '0);

    // Basic issue rd=3, rs=(1,2,-).
    drive(1, 3, 1, {5'd0, 5'd2, 5'd1}, 3'b011, 16'h1234); step();
    drive(0, 0, 0, '0, 3'b000, '0);
    chk("t1_valid", acc_valid, 1);
    chk("t1_rd", acc_rd, 3);
    chk("t1_op0", acc_op[63:0], 64'h3FF0000000000000);
    chk("t1_op1", acc_op[127:64], 64'h4000000000000000);
    chk("t1_op2", acc_op[191:128], 0);
    chk("t1_pend3", pending[3], 1);

    // RAW stall then bypass.
    drive(1, 4, 1, {5'd0, 5'd0, 5'd3}, 3'b001, 16'h2222);
    #1 chk("t2_stall0", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_stall", in_ready, 0);
    end
    wbset(1, 3, 64'h4008000000000000);
    #1 chk("t2_ready", in_ready, 1);
    step();
    drive(0, 0, 0, '0, 3'b000, '0);
    wbset(0, 0, '0);
    chk("t2_rd", acc_rd, 4);
    chk("t2_bypass", acc_op[63:0], 64'h4008000000000000);
    chk("t2_pend", pending[4:3], 2'b10);

    // WAW stall on rd=5.
    drive(1, 5, 1, '0, 3'b000, 16'h5555); step();
    #1 chk("t3_stall0", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_stall", in_ready, 0);
    end
    wbset(1, 5, 64'h1111);
    #1 chk("t3_ready", in_ready, 1);
    step();
    drive(0, 0, 0, '0, 3'b000, '0);
    wbset(0, 0, '0);
    chk("t3_pend5", pending[5], 1);
    chk("t3_valid", acc_valid, 1);
    wbset(1, 4, 64'h44); step();
    wbset(1, 5, 64'h55); step();
    wbset(0, 0, '0);
    chk("t3_clean", pending, 0);

    // Back-pressure hold then streaming.
    acc_ready = 1'b0;
    drive(1, 6, 0, '0, 3'b000, 16'hBEEF); step();
    drive(1, 7, 0, '0, 3'b000, 16'hC000);
    chk("t4_full", acc_valid, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_hold_valid", acc_valid, 1);
      chk("t4_hold_pl", acc_payload, 16'hBEEF);
      chk("t4_hold_rd", acc_rd, 6);
      chk("t4_hold_ready", in_ready, 0);
    end
    acc_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 7, 0, '0, 3'b000, 16'hC000 + 16'(i));
      step();
      chk("t4_stream", acc_payload, 16'hC000 + 16'(i));
    end
    drive(0, 0, 0, '0, 3'b000, '0);
    step();
    chk("t4_drain", acc_valid, 0);

    // Write-back to a non-pending register.
    wbset(1, 7, 64'hDEADBEEF00000007); step();
    wbset(0, 0, '0);
    chk("t5_err", err, ErrEn);
    drive(1, 8, 0, {5'd0, 5'd0, 5'd7}, 3'b001, 16'h0008); step();
    drive(0, 0, 0, '0, 3'b000, '0);
    chk("t5_reg7", acc_op[63:0], 64'hDEADBEEF00000007);
    repeat (3) step();
    chk("t5_err_sticky", err, ErrEn);

    // Asynchronous reset during a stall with pending=0x18.
    drive(1, 3, 1, '0, 3'b000, '0); step();
    drive(1, 4, 1, '0, 3'b000, '0); step();
    drive(1, 9, 1, {5'd0, 5'd0, 5'd3}, 3'b001, '0); step();
    chk("t6_pend", pending, 32'h18);
    chk("t6_stall", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_valid", acc_valid, 0);
    chk("t6_rst_idle", idle, 1);
    chk("t6_rst_err", err, 0);
    drive(0, 0, 0, '0, 3'b000, '0);
    step();
    rst = 1'b0;

    // Randomized traffic on a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] a;
      drive(($urandom % 4) != 0, AW'($urandom_range(7, 0)), ($urandom % 4) != 0,
            {AW'($urandom_range(7, 0)), AW'($urandom_range(7, 0)), AW'($urandom_range(7, 0))},
            3'($urandom), 16'($urandom));
      acc_ready = ($urandom % 4) != 0;
      a = AW'($urandom_range(7, 0));
      if (m_pend[a] || ($urandom % 32) == 0) wbset(1, a, {$urandom, $urandom});
      else wbset(0, 0, '0);
      step();
    end
    drive(0, 0, 0, '0, 3'b000, '0);
    wbset(0, 0, '0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
